tick_sequencer: RTL and testbench

TICK_SEQUENCER -- requirements
Module: tick_sequencer

---
 rtl/tick_seq_pkg.sv | 14 +
 rtl/mod_counter.sv | 32 +++
 rtl/tick_sequencer.sv | 126 ++++++++++++
 tb/tb_tick_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tick_seq_pkg.sv
// Shared definitions for the tick sequencer: sequencer state encoding and
// default widths for the divisor/divider and burst/tick counters.
// No ports; imported by tick_sequencer and mod_counter.
package tick_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_DIV_BITS   = 8;
  localparam int DEFAULT_BURST_BITS = 4;

endpackage

// File: rtl/mod_counter.sv
// Purpose: modulo counter, counts 0..modulus then wraps to 0 while enabled.
// Latency: terminal is a combinational decode of the registered count.
// Ports: clk, reset (sync, active-high), clear (sync, beats enable),
//        enable, modulus (last value before wrap), terminal (count == modulus).
module mod_counter #(
  parameter int W = tick_seq_pkg::DEFAULT_DIV_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] modulus,
  output logic         terminal
);

  logic [W-1:0] count;

  assign terminal = (count == modulus);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      if (terminal) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_sequencer.sv
// Purpose: periodic tick generator with optional burst length, start/stop control.
// Latency: run begins the cycle after start; first tick cfg_div+1 cycles into the run;
//          done is a registered pulse the cycle after the final tick.
// Backpressure: cfg_ready is high only in IDLE; config offered during RUN is dropped.
// Ports: clk, reset (sync, active-high), cfg_valid/cfg_ready/cfg_div/cfg_burst
//        (config handshake), start, stop, tick, busy, done, tick_count.
module tick_sequencer
  import tick_seq_pkg::*;
#(
  parameter int DIV_BITS   = DEFAULT_DIV_BITS,
  parameter int BURST_BITS = DEFAULT_BURST_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DIV_BITS-1:0]   cfg_div,
  input  logic [BURST_BITS-1:0] cfg_burst,
  input  logic                  start,
  input  logic                  stop,
  output logic                  tick,
  output logic                  busy,
  output logic                  done,
  output logic [BURST_BITS-1:0] tick_count
);

  state_t                state;
  state_t                state_next;
  logic [DIV_BITS-1:0]   div_q;
  logic [BURST_BITS-1:0] burst_q;
  logic [BURST_BITS-1:0] tick_count_inc;
  logic                  div_term;
  logic                  div_clear;
  logic                  cfg_accept;
  logic                  start_run;
  logic                  last_tick;
  logic                  done_next;

  assign busy           = (state == RUN);
  assign cfg_ready      = (state == IDLE);
  assign tick           = busy & div_term;
  assign cfg_accept     = cfg_valid & cfg_ready;
  assign start_run      = start & cfg_ready;
  assign tick_count_inc = tick_count + 1'b1;

  // Burst of 0 means run forever; otherwise the tick that makes the count
  // reach the burst length is the last one.
  assign last_tick = tick && (burst_q != '0) && (tick_count_inc == burst_q);

  // Holding the divider clear throughout IDLE guarantees every run starts
  // from 0; a stop clears it on the way out of RUN.
  assign div_clear = cfg_ready | stop;

  mod_counter #(
    .W (DIV_BITS)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .clear    (div_clear),
    .enable   (busy),
    .modulus  (div_q),
    .terminal (div_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stop wins over completion, so a stop on the final tick gives no done.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (last_tick) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= done_next;
    end
  end

  // Config is latched at the same edge as a coincident start, so that run
  // already uses the new values. tick_count holds through IDLE and is only
  // cleared by the next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      burst_q    <= '0;
      tick_count <= '0;
    end else begin
      if (cfg_accept) begin
        div_q   <= cfg_div;
        burst_q <= cfg_burst;
      end
      if (start_run) begin
        tick_count <= '0;
      end else if (tick) begin
        tick_count <= tick_count_inc;
      end
    end
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a run-cycle based model.
module tb_tick_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_div = '0;
  logic [3:0] cfg_burst = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       tick;
  logic       busy;
  logic       done;
  logic [3:0] tick_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tick_sequencer #(
    .DIV_BITS   (8),
    .BURST_BITS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_div    (cfg_div),
    .cfg_burst  (cfg_burst),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .tick_count (tick_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is a count of cycles since start (first RUN
  // cycle = 1); a tick falls on every multiple of (div+1).
  bit m_ok    = 1'b0;
  bit m_busy  = 1'b0;
  int m_cyc   = 0;
  int m_div   = 0;
  int m_burst = 0;
  int m_tc    = 0;
  bit m_done  = 1'b0;

  function automatic bit m_tick();
    return m_busy && ((m_cyc % (m_div + 1)) == 0);
  endfunction

  // Compare at the falling edge, then advance the model with the inputs
  // that the next rising edge will sample.
  initial begin
    logic [7:0] exp_v;
    logic [7:0] act_v;
    bit t;
    bit nd;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        exp_v = {m_tick(), m_busy, !m_busy, m_done, 4'(m_tc)};
        act_v = {tick, busy, cfg_ready, done, tick_count};
        chk("model", {24'd0, act_v}, {24'd0, exp_v});
      end
      if (reset) begin
        m_ok = 1'b1; m_busy = 1'b0; m_cyc = 0; m_div = 0;
        m_burst = 0; m_tc = 0; m_done = 1'b0;
      end else if (m_ok) begin
        t  = m_tick();
        nd = 1'b0;
        if (!m_busy) begin
          if (cfg_valid) begin
            m_div   = int'(cfg_div);
            m_burst = int'(cfg_burst);
          end
          if (start) begin
            m_busy = 1'b1; m_cyc = 1; m_tc = 0;
          end
        end else begin
          if (t) m_tc = (m_tc + 1) % 16;
          if (stop) begin
            m_busy = 1'b0;
          end else if (t && m_burst != 0 && m_tc == m_burst) begin
            m_busy = 1'b0;
            nd = 1'b1;
          end else begin
            m_cyc++;
          end
        end
        m_done = nd;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] d, input logic [3:0] b);
    cfg_valid = 1'b1; cfg_div = d; cfg_burst = b; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    logic [31:0] mask;
    int ticks;
    bit dn;

    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {24'd0, tick, busy, cfg_ready, done, tick_count}, 32'h20);
    cyc();

    // div 3, burst 2: ticks in RUN cycles 4 and 8, done and idle in cycle 9
    launch(8'd3, 4'd2);
    mask = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (tick) mask[c] = 1'b1;
      if (c == 9) chk("burst2_end", {26'd0, busy, done, tick_count}, 32'h12);
      cyc();
    end
    chk("burst2_tick_cycles", mask, 32'h110);

    // div 0, continuous: tick every cycle, count wraps 15 -> 0, no done
    launch(8'd0, 4'd0);
    ticks = 0; dn = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ticks += int'(tick);
      dn |= done;
      if (c == 16) chk("cont_count_15", {28'd0, tick_count}, 32'd15);
      if (c == 17) chk("cont_count_wrap", {28'd0, tick_count}, 32'd0);
      cyc();
    end
    chk("cont_ticks", ticks, 32'd20);
    chk("cont_no_done", {31'd0, dn}, 32'd0);
    stop = 1'b1; cyc(); stop = 1'b0;

    // div 2, burst 5, stop in RUN cycle 7
    launch(8'd2, 4'd5);
    dn = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      stop = (c == 7);
      @(negedge clk);
      dn |= done;
      cyc();
    end
    stop = 1'b0;
    @(negedge clk);
    chk("stop_mid_state", {26'd0, busy, done, tick_count}, 32'h02);
    chk("stop_mid_no_done", {31'd0, dn}, 32'd0);
    cyc();

    // div 1, burst 1, stop on the final tick: counted, done suppressed
    launch(8'd1, 4'd1);
    for (int c = 1; c <= 2; c++) begin
      stop = (c == 2);
      @(negedge clk);
      if (c == 2) chk("stop_final_tick", {31'd0, tick}, 32'd1);
      cyc();
    end
    stop = 1'b0;
    @(negedge clk);
    chk("stop_final_state", {26'd0, busy, done, tick_count}, 32'h01);
    cyc();

    // config offered during RUN is ignored
    launch(8'd1, 4'd0);
    mask = '0;
    for (int c = 1; c <= 8; c++) begin
      cfg_valid = (c <= 4); cfg_div = 8'd9;
      @(negedge clk);
      if (c == 2) chk("run_cfg_ready", {31'd0, cfg_ready}, 32'd0);
      if (tick) mask[c] = 1'b1;
      cyc();
    end
    cfg_valid = 1'b0;
    chk("run_cfg_ignored", mask, 32'h154);
    stop = 1'b1; cyc(); stop = 1'b0;

    // same config offered with start in IDLE takes effect
    launch(8'd9, 4'd0);
    mask = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (tick) mask[c] = 1'b1;
      cyc();
    end
    chk("idle_cfg_period10", mask, 32'h100400);
    stop = 1'b1; cyc(); stop = 1'b0;

    // reset in RUN cycle 3
    launch(8'd1, 4'd0);
    for (int c = 1; c <= 3; c++) begin
      reset = (c == 3);
      @(negedge clk);
      cyc();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("reset_in_run", {24'd0, tick, busy, cfg_ready, done, tick_count}, 32'h20);
    cyc();

    // randomized traffic, checked by the model every cycle
    repeat (4000) begin
      reset     = ($urandom_range(0, 149) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_div   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 20))
                                               : 8'($urandom_range(0, 4));
      cfg_burst = 4'($urandom_range(0, 15));
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      cyc();
    end
    reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
